stream_reorder: RTL and testbench
=================================

STREAM_REORDER -- requirements
Module: stream_reorder

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32: data word width in bits, legal range 1..128.
REQ-002 The module SHALL have parameter MAX_SLICE, default 8: largest runtime slice size, legal range 1..DATA_W.
REQ-003 The module SHALL have localparam SLICE_W = $clog2(MAX_SLICE+1): width of the slice-size field.
REQ-004 clk  input  1  sole clock; every flop SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  input beat valid.
REQ-007 in_ready  output  1  module can accept an input beat.
REQ-008 in_data  input  DATA_W  word to be reordered.
REQ-009 in_slice  input  SLICE_W  slice size for this beat.
REQ-010 in_dir  input  1  per-beat direction: 0 = right-stream (pass-through), 1 = left-stream (slice reversal).
REQ-011 out_valid  output  1  output beat valid.
REQ-012 out_ready  input  1  downstream accepts.
REQ-013 out_data  output  DATA_W  reordered word.
REQ-014 beat_count  output  32  count of accepted output beats.

Function
REQ-015 An input transfer SHALL occur when in_valid && in_ready are both high at a rising edge; an output transfer SHALL occur when out_valid && out_ready are both high.
REQ-016 Effective slice s SHALL be derived from in_slice as follows:
- in_slice = 0 gives s = 1;
- in_slice > MAX_SLICE gives s = MAX_SLICE;
- any other value gives s = in_slice.
REQ-017 With in_dir = 0, out_data SHALL equal in_data unchanged.
REQ-018 With in_dir = 1, left-stream SHALL be performed:
- split in_data into slices from the LSB upward: slice k = in_data[k*s +: min(s, DATA_W-k*s)], the last slice possibly short;
- place slice 0 at the MSB end of out_data, then slice 1, and so on;
- bit order within each slice SHALL be preserved.
REQ-019 With in_dir = 1 and s >= DATA_W, out_data SHALL equal in_data.
REQ-020 in_slice and in_dir SHALL be captured with each beat; changing them between beats SHALL NOT affect beats already accepted.
REQ-021 The datapath SHALL be a two-stage elastic pipeline:
- S1 registers data, s and dir;
- S2 registers the reordered result.
REQ-022 Latency SHALL be 2 cycles from input transfer to out_valid, with out_ready held high.
REQ-023 Sustained throughput SHALL be 1 beat per cycle while out_ready is high.
REQ-024 Each stage SHALL load when it is empty or when its contents move forward in the same cycle.
REQ-025 in_ready SHALL equal !S1_full || (S1 advances this cycle); in_ready MAY depend combinationally on out_ready.
REQ-026 While out_ready is low and both stages are full, in_ready SHALL be low and both stages SHALL hold.
REQ-027 out_data SHALL remain stable while out_valid && !out_ready.
REQ-028 No beat SHALL be dropped, duplicated or reordered under any valid/ready pattern.
REQ-029 Simultaneous input and output transfers on a full pipeline SHALL be accepted in the same cycle.

Reset
REQ-030 While rst is high at a rising edge, the following SHALL clear: both stage-valid flags, out_valid, out_data, beat_count (all 0); in_ready SHALL be 1 in the cycle after reset.
REQ-031 Assertion of rst mid-operation SHALL discard all in-flight beats without emitting them.
REQ-032 No beat SHALL be accepted in a cycle where rst is high.

Configuration
REQ-033 With macro STREAM_REORDER_STATS_EN defined:
- beat_count SHALL increment by 1 on each output transfer;
- beat_count SHALL wrap from 0xFFFFFFFF to 0.
REQ-034 Without STREAM_REORDER_STATS_EN, beat_count SHALL be tied to constant 0 and no counter flops SHALL exist.

Verification
REQ-035 DATA_W=4, dir=1, in_data 4'b0001 with slices 1,2,3,4,5 -> out_data 1000, 0100, 0010, 0001, 0001; dir=0 -> 0001 for every slice.
REQ-036 DATA_W=32, dir=1:
- slice=1, in_data 32'h04030201 -> 32'h8040C020;
- slice=3, in_data 32'hD70A4497 -> 32'hE92910EB.
REQ-037 DATA_W=11, dir=1, slice=4, in_data 11'b10010010111 -> 11'h3CC; in_slice=0 behaves as slice 1; slice above MAX_SLICE clamps.
REQ-038 Random in_valid/out_ready at 50% each, 1000 beats with random slice and dir -> output sequence matches the reference model exactly, and out_data is stable while stalled.
REQ-039 With out_ready low, feed 3 beats -> in_ready falls after 2 accepted; raise out_ready -> all 3 emerge in order, with beat_count = 3 when STREAM_REORDER_STATS_EN is defined and 0 when it is not.
REQ-040 Assert rst for 1 cycle with 2 beats in flight -> out_valid = 0 on the next cycle, no stale beat appears afterward, and beat_count = 0.

Source files
------------

// File: rtl/stream_reorder.sv
// stream_reorder: two-stage elastic pipeline that either passes a word through
// unchanged (dir = 0) or performs a left-stream slice reversal (dir = 1).
// Slices are cut from the LSB upward and laid down from the MSB downward, so
// slice 0 lands at the top of the output word. Bit order inside a slice is kept.
//
// Optional feature: define STREAM_REORDER_STATS_EN to build the 32-bit
// output-beat counter on beat_count. Without it, beat_count is tied to zero.
//
// Handshake: a beat moves across an interface only on a rising edge where
// valid and ready are both high. A producer holding valid with ready low keeps
// its beat, and out_data stays stable while out_valid is high and out_ready is
// low. in_ready is combinational from out_ready so a full pipeline can accept
// and emit in the same cycle. No beat is accepted while rst is high.
module stream_reorder #(
   parameter int DATA_W    = 32,
   parameter int MAX_SLICE = 8,
   localparam int SLICE_W  = $clog2(MAX_SLICE + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [SLICE_W-1:0] in_slice,
   input  logic               in_dir,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic [31:0]        beat_count
);

   // Stage 1 holds the raw word with its effective slice size and direction.
   logic               s1_valid;
   logic [DATA_W-1:0]  s1_data;
   logic [SLICE_W-1:0] s1_slice;
   logic               s1_dir;

   // Stage 2 holds the finished, reordered word.
   logic               s2_valid;
   logic [DATA_W-1:0]  s2_data;

   logic               s2_ready;
   logic               in_fire;
   logic               out_fire;
   logic [SLICE_W-1:0] eff_slice;
   logic [DATA_W-1:0]  rev_data;

   // Output position of input bit i when the word is cut into c-bit slices.
   // Every slice before the last is exactly c bits wide, so slice k starts at
   // input bit k*c and its top bit sits k*c bits below the output MSB.
   function automatic int dst_bit(input int i, input int c);
      int base;
      int len;
      base = (i / c) * c;
      len  = (DATA_W - base < c) ? (DATA_W - base) : c;
      return DATA_W - base - len + (i - base);
   endfunction

   // Stage 2 can take a new word when empty or when its word leaves now.
   assign s2_ready  = !s2_valid || out_ready;
   assign in_ready  = !rst && (!s1_valid || s2_ready);
   assign in_fire   = in_valid && in_ready;
   assign out_valid = s2_valid;
   assign out_data  = s2_data;
   assign out_fire  = s2_valid && out_ready;

   // Clamp the requested slice size: zero means single bits, oversize saturates.
   always_comb begin
      eff_slice = in_slice;
      if (in_slice == '0) begin
         eff_slice = SLICE_W'(1);
      end else if (in_slice > SLICE_W'(MAX_SLICE)) begin
         eff_slice = SLICE_W'(MAX_SLICE);
      end
   end

   // Reorder stage-1 data: one fixed bit permutation per legal slice size,
   // selected by the captured slice; a slice covering the word is identity.
   always_comb begin
      rev_data = s1_data;
      if (s1_dir) begin
         for (int c = 1; c <= MAX_SLICE; c++) begin
            if (s1_slice == SLICE_W'(c)) begin
               for (int i = 0; i < DATA_W; i++) begin
                  rev_data[dst_bit(i, c)] = s1_data[i];
               end
            end
         end
      end
   end

   // Stage 1 register: loads whenever it is empty or draining this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_slice <= '0;
         s1_dir   <= 1'b0;
      end else begin
         if (in_ready) begin
            s1_valid <= in_valid;
         end
         if (in_fire) begin
            s1_data  <= in_data;
            s1_slice <= eff_slice;
            s1_dir   <= in_dir;
         end
      end
   end

   // Stage 2 register: loads the reordered word unless stalled downstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_data  <= '0;
      end else if (s2_ready) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_data <= rev_data;
         end
      end
   end

`ifdef STREAM_REORDER_STATS_EN
   logic [31:0] count_q;

   // Count output transfers; natural 32-bit wrap from all-ones to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (out_fire) begin
         count_q <= count_q + 32'd1;
      end
   end

   assign beat_count = count_q;
`else
   logic unused_fire;

   assign unused_fire = out_fire;
   assign beat_count  = '0;
`endif

endmodule

// File: tb/tb_stream_reorder.sv
// tb_stream_reorder: bench for stream_reorder at widths 4, 11 and 32.
// Fixed vectors, a randomized valid/ready run against a slice-list reference
// model, a back-pressure sequence and a mid-flight reset sequence.
module tb_stream_reorder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef STREAM_REORDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // 32-bit instance (main)
  logic        in_valid, in_ready, in_dir, out_valid, out_ready;
  logic [31:0] in_data, out_data, beat_count;
  logic [3:0]  in_slice;

  // 4-bit instance
  logic        v4, r4, dir4, ov4;
  logic [3:0]  d4, od4;
  logic [2:0]  sl4;
  logic [31:0] bc4;

  // 11-bit instance
  logic        v11, r11, dir11, ov11;
  logic [10:0] d11, od11;
  logic [3:0]  sl11;
  logic [31:0] bc11;

  stream_reorder #(.DATA_W(32), .MAX_SLICE(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_slice(in_slice), .in_dir(in_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .beat_count(beat_count));

  stream_reorder #(.DATA_W(4), .MAX_SLICE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4),
    .in_data(d4), .in_slice(sl4), .in_dir(dir4),
    .out_valid(ov4), .out_ready(1'b1), .out_data(od4),
    .beat_count(bc4));

  stream_reorder #(.DATA_W(11), .MAX_SLICE(8)) u_dut11 (
    .clk(clk), .rst(rst), .in_valid(v11), .in_ready(r11),
    .in_data(d11), .in_slice(sl11), .in_dir(dir11),
    .out_valid(ov11), .out_ready(1'b1), .out_data(od11),
    .beat_count(bc11));

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int beats_main = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    int           w;
    logic [127:0] d;
    int           sl;
    bit           dir;
    logic [127:0] exp;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_bc(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  // Reference: cut the word into a list of slices from the LSB, then lay the
  // list down starting at the MSB end.
  function automatic logic [127:0] ref_ls(input logic [127:0] d, input int w,
                                          input int sl, input int maxs, input bit dir);
    int s;
    int pos;
    int len;
    logic [127:0] res;
    logic [127:0] piece;
    logic [127:0] mask;
    s = (sl == 0) ? 1 : ((sl > maxs) ? maxs : sl);
    if (!dir) return d;
    res = '0;
    pos = w;
    for (int st = 0; st < w; st += s) begin
      len   = (w - st < s) ? (w - st) : s;
      mask  = (128'd1 << len) - 128'd1;
      piece = (d >> st) & mask;
      pos   = pos - len;
      res   = res | (piece << pos);
    end
    return res;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; v4 = 1'b0; v11 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    beats_main = 0;
    exp_q.delete();
  endtask

  // Send one beat into the selected instance on an idle pipeline and report
  // the output word and how many negedges after acceptance it appeared.
  task automatic run_vec(input int w, input logic [127:0] d, input int sl, input bit dir,
                         output logic [127:0] got, output int lat);
    got = '0;
    lat = 0;
    case (w)
      4: begin
        v4 = 1'b1; d4 = d[3:0]; sl4 = 3'(sl); dir4 = dir;
      end
      11: begin
        v11 = 1'b1; d11 = d[10:0]; sl11 = 4'(sl); dir11 = dir;
      end
      default: begin
        in_valid = 1'b1; in_data = d[31:0]; in_slice = 4'(sl); in_dir = dir;
      end
    endcase
    @(posedge clk);
    #1;
    v4 = 1'b0; v11 = 1'b0; in_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (lat == 0) begin
        if (w == 4 && ov4) begin
          got = 128'(od4); lat = c;
        end else if (w == 11 && ov11) begin
          got = 128'(od11); lat = c;
        end else if (w == 32 && out_valid) begin
          got = 128'(out_data); lat = c;
          beats_main++;
        end
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [127:0] got;
    logic [127:0] tmp;
    logic [31:0]  held;
    logic [31:0]  b [3];
    int           bsl [3];
    bit           stalled;
    bit           took2;
    int           lat;
    int           sent;
    int           cyc;
    int           seen;

    in_valid = 0; in_data = '0; in_slice = '0; in_dir = 0; out_ready = 1'b1;
    v4 = 0; d4 = '0; sl4 = '0; dir4 = 0;
    v11 = 0; d11 = '0; sl11 = '0; dir11 = 0;

    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", 128'(out_data), 128'd0);
    chk("rst_beat_count", 128'(beat_count), 128'd0);
    chk("rst_out_valid4", 128'(ov4), 128'd0);
    chk("rst_out_valid11", 128'(ov11), 128'd0);

    // fixed vectors
    tv.push_back('{4, 128'h1, 1, 1'b1, 128'h8});
    tv.push_back('{4, 128'h1, 2, 1'b1, 128'h4});
    tv.push_back('{4, 128'h1, 3, 1'b1, 128'h2});
    tv.push_back('{4, 128'h1, 4, 1'b1, 128'h1});
    tv.push_back('{4, 128'h1, 5, 1'b1, 128'h1});
    for (int s = 1; s <= 5; s++) tv.push_back('{4, 128'h1, s, 1'b0, 128'h1});
    tv.push_back('{32, 128'h04030201, 1, 1'b1, 128'h8040C020});
    tv.push_back('{32, 128'hD70A4497, 3, 1'b1, 128'hE92910EB});
    tv.push_back('{32, 128'h04030201, 8, 1'b1, 128'h01020304});
    tv.push_back('{32, 128'hD70A4497, 3, 1'b0, 128'hD70A4497});
    tv.push_back('{11, 128'h497, 4, 1'b1, 128'h3CC});
    tv.push_back('{11, 128'h497, 1, 1'b1, 128'h749});
    tv.push_back('{11, 128'h497, 0, 1'b1, 128'h749});
    tv.push_back('{11, 128'h497, 8, 1'b1, 128'h4BC});
    tv.push_back('{11, 128'h497, 9, 1'b1, 128'h4BC});
    tv.push_back('{11, 128'h497, 15, 1'b1, 128'h4BC});

    foreach (tv[i]) begin
      run_vec(tv[i].w, tv[i].d, tv[i].sl, tv[i].dir, got, lat);
      chk($sformatf("vec%0d_w%0d_data", i, tv[i].w), got, tv[i].exp);
      chk($sformatf("vec%0d_w%0d_latency", i, tv[i].w), 128'(lat), 128'd2);
    end
    @(negedge clk);
    chk("vec_beat_count", 128'(beat_count), 128'(exp_bc(beats_main)));

    // randomized valid/ready against the reference model
    sent = 0; cyc = 0; stalled = 0; held = '0;
    while ((sent < 1000 || exp_q.size() > 0) && cyc < 20000) begin
      @(posedge clk);
      #1;
      if (sent < 1000) begin
        in_valid = ($urandom_range(0, 1) == 1);
        in_data  = $urandom;
        in_slice = 4'($urandom_range(0, 15));
        in_dir   = 1'($urandom_range(0, 1));
        out_ready = ($urandom_range(0, 1) == 1);
      end else begin
        in_valid = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (stalled) begin
        chk("rand_stall_valid", 128'(out_valid), 128'd1);
        chk("rand_stall_data", 128'(out_data), 128'(held));
      end
      if (out_valid && out_ready) begin
        stalled = 0;
        if (exp_q.size() == 0) begin
          chk("rand_extra_beat", 128'(out_data), 128'hx);
        end else begin
          chk("rand_data", 128'(out_data), 128'(exp_q.pop_front()));
          beats_main++;
        end
      end else if (out_valid) begin
        stalled = 1;
        held = out_data;
      end else begin
        stalled = 0;
      end
      if (in_valid && in_ready) begin
        tmp = ref_ls(128'(in_data), 32, int'(in_slice), 8, in_dir);
        exp_q.push_back(tmp[31:0]);
        sent++;
      end
      cyc++;
    end
    chk("rand_sent", 128'(sent), 128'd1000);
    chk("rand_drained", 128'(exp_q.size()), 128'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rand_beat_count", 128'(beat_count), 128'(exp_bc(beats_main)));

    // back-pressure: three beats with output blocked
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      b[k] = $urandom;
      bsl[k] = $urandom_range(1, 8);
      tmp = ref_ls(128'(b[k]), 32, bsl[k], 8, 1'b1);
      exp_q.push_back(tmp[31:0]);
    end
    @(posedge clk);
    #1 in_valid = 1'b1; in_dir = 1'b1; in_data = b[0]; in_slice = 4'(bsl[0]);
    @(negedge clk);
    chk("bp_ready0", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1 in_data = b[1]; in_slice = 4'(bsl[1]);
    @(negedge clk);
    chk("bp_ready1", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1 in_data = b[2]; in_slice = 4'(bsl[2]);
    @(negedge clk);
    chk("bp_ready2", 128'(in_ready), 128'd0);
    chk("bp_valid_held", 128'(out_valid), 128'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_still_blocked", 128'(in_ready), 128'd0);
    chk("bp_head_stable", 128'(out_data), 128'(exp_q[0]));
    @(posedge clk);
    #1 out_ready = 1'b1;
    seen = 0; took2 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("bp_extra_beat", 128'(out_data), 128'hx);
        end else begin
          chk($sformatf("bp_out%0d", seen), 128'(out_data), 128'(exp_q.pop_front()));
          seen++;
        end
      end
      if (in_valid && in_ready) took2 = 1;
      @(posedge clk);
      #1;
      if (took2) in_valid = 1'b0;
    end
    chk("bp_count_out", 128'(seen), 128'd3);
    @(negedge clk);
    chk("bp_beat_count", 128'(beat_count), 128'(exp_bc(3)));

    // reset with two beats in flight
    do_reset();
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b1; in_dir = 1'b0; in_data = 32'hA5A5_0001; in_slice = 4'd1;
    @(posedge clk);
    #1 in_data = 32'hA5A5_0002;
    @(posedge clk);
    #1 in_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
    chk("mid_rst_beat_count", 128'(beat_count), 128'd0);
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mid_rst_no_stale", 128'(seen), 128'd0);
    chk("mid_rst_beat_count_after", 128'(beat_count), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
